irq_pending_arb: RTL
====================

# irq_pending_arb

Request collector and arbiter placed directly upstream of the priority-index consumer logic. Captures per-line request levels into a sticky pending register and selects the highest-numbered pending line (MSB wins, same priority order as the existing priority encoder). Presents the winner's binary index through a valid/ready handshake, and clears the granted pending bit on acceptance. Sustains one grant per cycle while the consumer keeps `ready` high.

## Interface
- `IN_WIDTH`, default 4: number of request lines; must be ≥2.
- `OUT_WIDTH`, localparam `$clog2(IN_WIDTH)`: index width.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  IN_WIDTH  request levels; any bit high in a cycle sets the matching pending bit.
- `valid`  out  1  `index` holds a granted line.
- `index`  out  OUT_WIDTH  binary index of the presented line.
- `ready`  in  1  consumer accepts `index` when `valid && ready`.
- `pending`  out  IN_WIDTH  current pending register (registered).
- `mask_we`  in  1  mask write strobe (only with `IRQ_PENDING_MASK_EN`).
- `mask_wdata`  in  IN_WIDTH  new mask value; bit=1 blocks the line (only with `IRQ_PENDING_MASK_EN`).

## Operation
- Pending update each cycle: `pending_next = (pending & ~clr) | req`, where `clr` is the one-hot of `index` when `valid && ready`, otherwise 0. Set wins over clear on the same bit.
- Eligible set: `pending & ~mask`. Winner: the highest set bit of the eligible set.
- FSM, 2 states:
  - IDLE: `valid`=0. If the eligible set computed from the registered `pending` is nonzero, load `index` with the winner and go to PRESENT.
  - PRESENT: `valid`=1, and `index` is held stable while `ready`=0. This holds even if higher-priority requests arrive, or if the presented line becomes masked. `valid` is never withdrawn without a handshake.
  - PRESENT with handshake: recompute the eligible set from `pending_next`.
    - Nonzero: stay in PRESENT, load `index` with the new winner.
    - Zero: go to IDLE.
- A line held high on `req` re-pends every cycle. A source deasserts after it observes its grant.
- No counters and no overflow tracking: repeated requests on an already-pending line merge into one pending bit.

## Timing
- Reset values: `valid`=0, `index`=0, `pending`=0, FSM=IDLE, `mask`=0.
- `rst` has priority over every other input, including mid-handshake. A grant on the reset cycle is discarded.
- Latency from IDLE: `req` bit high in cycle N gives `pending` bit set in N+1, and `valid`/`index` in N+2.
- Back-to-back: a handshake in cycle N makes the next winner visible in N+1. No bubble cycle is inserted while eligible lines remain.
- `pending` output reflects the set and clear from the previous edge.
- Mask write: takes effect on the edge after `mask_we`. The new mask is used for the next selection decision and never alters an already-presented `index`.

## Configuration
- `IRQ_PENDING_MASK_EN` defined:
  - `mask_we` and `mask_wdata` ports exist.
  - The mask register resets to 0 and loads `mask_wdata` when `mask_we`=1.
  - Masked lines remain pending but are not selected.
- Not defined:
  - Mask ports are absent.
  - The mask is constant 0, so all pending lines are eligible.

## Test plan
- Reset: assert `rst` for 2 cycles with `req`=4'b1111. Required: `valid`=0, `index`=0, `pending`=0 throughout; `pending`=4'b1111 one cycle after release.
- Ordering: `req`=4'b0101 pulsed for one cycle, `ready`=1. Required: `pending`=0101 at +1; `valid`=1 with `index`=2 at +2; `index`=0 at +3; `valid`=0 and `pending`=0 at +4.
- Hold under backpressure: present `index`=1 with `ready`=0, then pulse `req`=4'b1000. Required: `index` stays 1 until `ready`=1; the next grant is 3.
- Set-wins: `req[2]` high in the handshake cycle of `index`=2. Required: `pending[2]` remains 1 and `index`=2 is presented again the next cycle.
- Reset mid-operation: `rst` while in PRESENT with `pending`=4'b1010. Required: next cycle `valid`=0, `pending`=0, `index`=0.
- Mask (macro defined): write mask 4'b1000, then pulse `req`=4'b1001. Required: only `index`=0 is granted and `pending` settles at 4'b1000. Write mask 0. Required: `index`=3 valid two cycles after the write.

Source files
------------

// File: rtl/irq_pending_arb_if.sv
// Handshake/request bundle between the pending-request arbiter and its consumer.
// Mask signals exist only when IRQ_PENDING_MASK_EN is defined.
interface irq_pending_arb_if #(
  parameter int IN_WIDTH = 4
);
  localparam int OUT_WIDTH = $clog2(IN_WIDTH);

  logic [IN_WIDTH-1:0]  req;
  logic                 valid;
  logic [OUT_WIDTH-1:0] index;
  logic                 ready;
  logic [IN_WIDTH-1:0]  pending;
`ifdef IRQ_PENDING_MASK_EN
  logic                 mask_we;
  logic [IN_WIDTH-1:0]  mask_wdata;
`endif

  // The arbiter is the source of valid/index, hence the master side.
  modport master (
    input  req,
    input  ready,
`ifdef IRQ_PENDING_MASK_EN
    input  mask_we,
    input  mask_wdata,
`endif
    output valid,
    output index,
    output pending
  );

  modport slave (
    output req,
    output ready,
`ifdef IRQ_PENDING_MASK_EN
    output mask_we,
    output mask_wdata,
`endif
    input  valid,
    input  index,
    input  pending
  );
endinterface

// File: rtl/irq_pending_arb.sv
// Sticky pending-request collector with MSB-wins arbitration and valid/ready grant.
// Optional per-line mask enabled by defining IRQ_PENDING_MASK_EN.
module irq_pending_arb #(
  parameter int IN_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  irq_pending_arb_if.master     arb
);
  localparam int OUT_WIDTH = $clog2(IN_WIDTH);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] index_q, index_d;
  logic [IN_WIDTH-1:0]  pending_q, pending_d;
  logic [IN_WIDTH-1:0]  mask_eff;
  logic [IN_WIDTH-1:0]  clr;
  logic [IN_WIDTH-1:0]  elig_cur;
  logic [IN_WIDTH-1:0]  elig_next;
  logic                 valid;
  logic                 handshake;

  function automatic logic [OUT_WIDTH-1:0] msb_index(input logic [IN_WIDTH-1:0] v);
    msb_index = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (v[i]) msb_index = OUT_WIDTH'(i);
    end
  endfunction

`ifdef IRQ_PENDING_MASK_EN
  logic [IN_WIDTH-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (arb.mask_we) begin
      mask_q <= arb.mask_wdata;
    end
  end

  assign mask_eff = mask_q;
`else
  assign mask_eff = '0;
`endif

  assign valid     = (state_q == ST_PRESENT);
  assign handshake = valid && arb.ready;

  generate
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_clr
      assign clr[gi] = handshake && (index_q == OUT_WIDTH'(gi));
    end
  endgenerate

  // Set wins over clear: a line re-requested in its own grant cycle stays pending.
  assign pending_d = (pending_q & ~clr) | arb.req;
  assign elig_cur  = pending_q & ~mask_eff;
  assign elig_next = pending_d & ~mask_eff;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig_cur) begin
          index_d = msb_index(elig_cur);
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Index is frozen until accepted, even if priorities or mask change.
        if (arb.ready) begin
          if (|elig_next) begin
            index_d = msb_index(elig_next);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pending_q <= pending_d;
    end
  end

  assign arb.valid   = valid;
  assign arb.index   = index_q;
  assign arb.pending = pending_q;
endmodule
